// File: rtl/msrv32_pkg.sv
// Shared msrv32 core types: register-file widths, address/data typedefs and the
// writeback request bundle seen by the register-file read ports.
package msrv32_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

  // Writeback request as presented to the register file in one cycle.
  typedef struct packed {
    reg_addr_t rd_addr;
    logic      wr_en;
    xlen_t     rd_data;
  } wb_req_t;

  // True when a read address matches a live, architecturally visible write.
  function automatic logic wb_hit(input reg_addr_t rs_addr, input wb_req_t wb);
    return wb.wr_en && (wb.rd_addr != ZERO_REG) && (rs_addr == wb.rd_addr);
  endfunction

endpackage

// File: rtl/msrv32_integer_file_if.sv
// Decode/writeback-facing bus of the integer register file: two read ports and
// one write port. The core drives through master; the register file is slave.
interface msrv32_integer_file_if;

  msrv32_pkg::reg_addr_t rs_1_addr_in;
  msrv32_pkg::reg_addr_t rs_2_addr_in;
  msrv32_pkg::xlen_t     rs_1_out;
  msrv32_pkg::xlen_t     rs_2_out;
  msrv32_pkg::reg_addr_t rd_addr_in;
  logic                  wr_en_in;
  msrv32_pkg::xlen_t     rd_in;

  modport master (
    output rs_1_addr_in,
    output rs_2_addr_in,
    output rd_addr_in,
    output wr_en_in,
    output rd_in,
    input  rs_1_out,
    input  rs_2_out
  );

  modport slave (
    input  rs_1_addr_in,
    input  rs_2_addr_in,
    input  rd_addr_in,
    input  wr_en_in,
    input  rd_in,
    output rs_1_out,
    output rs_2_out
  );

endinterface

// File: rtl/msrv32_rf_read_port.sv
// One combinational register-file read port: x0 forced to zero and, when
// MSRV32_RF_BYPASS_EN is defined, write-through forwarding of the current write.
module msrv32_rf_read_port
  import msrv32_pkg::*;
(
  input  reg_addr_t i_rs_addr,
  input  wb_req_t   i_wb,
  input  xlen_t     i_regs [NUM_REGS],
  output xlen_t     o_rs_data
);

`ifdef MSRV32_RF_BYPASS_EN
  // Forwarding beats stored contents; wb_hit already excludes x0.
  always_comb begin
    o_rs_data = '0;
    if (i_rs_addr != ZERO_REG) begin
      o_rs_data = i_regs[i_rs_addr];
    end
    if (wb_hit(i_rs_addr, i_wb)) begin
      o_rs_data = i_wb.rd_data;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^i_wb;

  always_comb begin
    o_rs_data = '0;
    if (i_rs_addr != ZERO_REG) begin
      o_rs_data = i_regs[i_rs_addr];
    end
  end
`endif

endmodule

// File: rtl/msrv32_integer_file.sv
// RV32I integer register file (x0 hardwired to zero), async active-low reset.
// Optional write-through bypass on both read ports: define MSRV32_RF_BYPASS_EN.
module msrv32_integer_file
  import msrv32_pkg::*;
(
  input logic                   clk_in,
  input logic                   reset_in,
  msrv32_integer_file_if.slave  rf_if
);

  xlen_t   r_regs [NUM_REGS];
  wb_req_t w_wb;
  xlen_t   w_rs_1_data;
  xlen_t   w_rs_2_data;

  // Write enable is qualified by reset so a bypass cannot leak data during reset.
  assign w_wb.rd_addr = rf_if.rd_addr_in;
  assign w_wb.wr_en   = rf_if.wr_en_in & reset_in;
  assign w_wb.rd_data = rf_if.rd_in;

  // Storage; entry 0 is only ever cleared, reads of x0 are forced in the port.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb.wr_en && (w_wb.rd_addr != ZERO_REG)) begin
      r_regs[w_wb.rd_addr] <= w_wb.rd_data;
    end
  end

  msrv32_rf_read_port u_rd_port_1 (
    .i_rs_addr (rf_if.rs_1_addr_in),
    .i_wb      (w_wb),
    .i_regs    (r_regs),
    .o_rs_data (w_rs_1_data)
  );

  msrv32_rf_read_port u_rd_port_2 (
    .i_rs_addr (rf_if.rs_2_addr_in),
    .i_wb      (w_wb),
    .i_regs    (r_regs),
    .o_rs_data (w_rs_2_data)
  );

  assign rf_if.rs_1_out = w_rs_1_data;
  assign rf_if.rs_2_out = w_rs_2_data;

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Directed self-checking bench for msrv32_integer_file; hazard expectations
// follow MSRV32_RF_BYPASS_EN when the build defines it.
module tb_msrv32_integer_file;

  logic clk_in;
  logic reset_in;
  int   n_chk;
  int   n_err;

  msrv32_integer_file_if rf_if ();

  msrv32_integer_file dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .rf_if    (rf_if)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk_in);
    rf_if.rd_addr_in = addr;
    rf_if.rd_in      = data;
    rf_if.wr_en_in   = 1'b1;
    @(posedge clk_in);
    #1;
    rf_if.wr_en_in   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      rf_if.rs_1_addr_in = 5'(a);
      rf_if.rs_2_addr_in = 5'(31 - a);
      #1;
      check_eq({tag, "_p1"}, rf_if.rs_1_out, 32'h0);
      check_eq({tag, "_p2"}, rf_if.rs_2_out, 32'h0);
    end
  endtask

  logic [31:0] hz_exp;

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_in           = 1'b0;
    rf_if.rs_1_addr_in = 5'd0;
    rf_if.rs_2_addr_in = 5'd0;
    rf_if.rd_addr_in   = 5'd0;
    rf_if.wr_en_in     = 1'b0;
    rf_if.rd_in        = 32'h0;

    // Random write attempts while reset is held must be ignored.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_in);
      rf_if.rd_addr_in   = 5'($urandom_range(1, 31));
      rf_if.rd_in        = $urandom | 32'h1;
      rf_if.wr_en_in     = 1'b1;
      rf_if.rs_1_addr_in = rf_if.rd_addr_in;
      rf_if.rs_2_addr_in = 5'($urandom_range(1, 31));
      #1;
      check_eq("in_reset_p1", rf_if.rs_1_out, 32'h0);
      check_eq("in_reset_p2", rf_if.rs_2_out, 32'h0);
    end
    @(negedge clk_in);
    rf_if.wr_en_in = 1'b0;
    reset_in       = 1'b1;
    check_all_zero("post_reset");

    // Basic write then read on both ports.
    wr_reg(5'd2, 32'h12345678);
    rf_if.rs_1_addr_in = 5'd2;
    rf_if.rs_2_addr_in = 5'd3;
    #1;
    check_eq("wr_x2_p1", rf_if.rs_1_out, 32'h12345678);
    check_eq("wr_x2_p2", rf_if.rs_2_out, 32'h0);
    rf_if.rs_2_addr_in = 5'd2;
    #1;
    check_eq("same_reg_p2", rf_if.rs_2_out, 32'h12345678);

    // x0 discards writes.
    wr_reg(5'd0, 32'hDEADBEEF);
    rf_if.rs_1_addr_in = 5'd0;
    rf_if.rs_2_addr_in = 5'd0;
    #1;
    check_eq("x0_p1", rf_if.rs_1_out, 32'h0);
    check_eq("x0_p2", rf_if.rs_2_out, 32'h0);

    // Same-cycle read/write hazard on x5, both ports.
    wr_reg(5'd5, 32'h11111111);
    @(negedge clk_in);
    rf_if.rs_1_addr_in = 5'd5;
    rf_if.rs_2_addr_in = 5'd5;
    rf_if.rd_addr_in   = 5'd5;
    rf_if.rd_in        = 32'hA5A5A5A5;
    rf_if.wr_en_in     = 1'b1;
    #1;
`ifdef MSRV32_RF_BYPASS_EN
    hz_exp = 32'hA5A5A5A5;
`else
    hz_exp = 32'h11111111;
`endif
    check_eq("hazard_pre_p1", rf_if.rs_1_out, hz_exp);
    check_eq("hazard_pre_p2", rf_if.rs_2_out, hz_exp);
    @(posedge clk_in);
    #1;
    rf_if.wr_en_in = 1'b0;
    #1;
    check_eq("hazard_post_p1", rf_if.rs_1_out, 32'hA5A5A5A5);
    check_eq("hazard_post_p2", rf_if.rs_2_out, 32'hA5A5A5A5);

    // Write to x0 while reading x0: never forwarded.
    @(negedge clk_in);
    rf_if.rs_1_addr_in = 5'd0;
    rf_if.rd_addr_in   = 5'd0;
    rf_if.rd_in        = 32'hCAFEF00D;
    rf_if.wr_en_in     = 1'b1;
    #1;
    check_eq("x0_bypass_p1", rf_if.rs_1_out, 32'h0);
    @(posedge clk_in);
    #1;
    rf_if.wr_en_in = 1'b0;

    // Disabled write leaves x7 untouched.
    @(negedge clk_in);
    rf_if.rd_addr_in   = 5'd7;
    rf_if.rd_in        = 32'hFFFF0000;
    rf_if.wr_en_in     = 1'b0;
    rf_if.rs_1_addr_in = 5'd7;
    @(posedge clk_in);
    #1;
    check_eq("wr_en0_x7", rf_if.rs_1_out, 32'h0);

    // Fill x1..x31 with their index, spot-check, then async reset mid-cycle.
    for (int a = 1; a < 32; a++) begin
      wr_reg(5'(a), 32'(a));
    end
    rf_if.rs_1_addr_in = 5'd31;
    rf_if.rs_2_addr_in = 5'd17;
    #1;
    check_eq("fill_x31", rf_if.rs_1_out, 32'd31);
    check_eq("fill_x17", rf_if.rs_2_out, 32'd17);
    rf_if.rs_2_addr_in = 5'd1;
    #1;
    check_eq("fill_x1", rf_if.rs_2_out, 32'd1);

    @(negedge clk_in);
    #2;
    rf_if.rd_addr_in = 5'd9;
    rf_if.rd_in      = 32'h99999999;
    rf_if.wr_en_in   = 1'b1;
    reset_in         = 1'b0;
    #1;
    check_eq("async_rst_p1", rf_if.rs_1_out, 32'h0);
    check_eq("async_rst_p2", rf_if.rs_2_out, 32'h0);
    rf_if.rs_1_addr_in = 5'd9;
    #1;
    check_eq("async_rst_x9", rf_if.rs_1_out, 32'h0);
    @(posedge clk_in);
    #1;
    check_eq("rst_wr_blocked", rf_if.rs_1_out, 32'h0);
    @(negedge clk_in);
    rf_if.wr_en_in = 1'b0;
    reset_in       = 1'b1;
    check_all_zero("after_mid_rst");

    // Writes resume normally after reset release.
    wr_reg(5'd9, 32'h0BADF00D);
    rf_if.rs_1_addr_in = 5'd9;
    #1;
    check_eq("resume_x9", rf_if.rs_1_out, 32'h0BADF00D);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
